// File: rtl/nfca_picc_tx.sv
// NFC-A card-side frame transmitter.
// Takes bytes from a valid/ready stream and drives the antenna load switch with
// Manchester-coded bits on an fc/16 subcarrier: SOF, data bits LSB first, odd
// parity after every full byte, then a silent EOF ETU.
module nfca_picc_tx #(
  parameter int ETU_CLKS  = 768,
  parameter int SUBC_CLKS = 96
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tvalid,
  output logic       tready,
  input  logic [7:0] tdata,
  input  logic [3:0] tdatab,
  input  logic       tlast,
  output logic       busy,
  output logic       underrun,
  output logic       load_mod
);

  localparam int CW = $clog2(ETU_CLKS);
  localparam int SW = $clog2(SUBC_CLKS);
  localparam logic [CW-1:0] ETU_LAST = CW'(ETU_CLKS - 1);
  localparam logic [CW-1:0] ETU_HALF = CW'(ETU_CLKS / 2);
  localparam logic [SW-1:0] SUB_LAST = SW'(SUBC_CLKS - 1);
  localparam logic [SW-1:0] SUB_HALF = SW'(SUBC_CLKS / 2);

  typedef enum logic [2:0] {
    S_IDLE, S_SOF, S_DATA, S_PARITY, S_EOF
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;       // position inside the current ETU
  logic [SW-1:0] sub_reg, sub_next;       // subcarrier phase, restarts every ETU
  logic [2:0]    bit_reg, bit_next;       // data bit index inside the byte
  logic [7:0]    data_reg, data_next;
  logic [3:0]    nbits_reg, nbits_next;   // number of data bits to send (1..8)
  logic          par_en_reg, par_en_next; // full byte: parity ETU follows the data
  logic          last_reg, last_next;

  logic etu_end;
  logic load_byte;
  logic ready_c;
  logic underrun_c;
  logic cur_bit;
  logic mod_half;
  logic load_mod_c;

  assign etu_end = (cnt_reg == ETU_LAST);

  // State, counters and latched byte; reset abandons any frame in flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      sub_reg    <= '0;
      bit_reg    <= '0;
      data_reg   <= '0;
      nbits_reg  <= '0;
      par_en_reg <= 1'b0;
      last_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      sub_reg    <= sub_next;
      bit_reg    <= bit_next;
      data_reg   <= data_next;
      nbits_reg  <= nbits_next;
      par_en_reg <= par_en_next;
      last_reg   <= last_next;
    end
  end

  // Frame sequencing, byte handshake and ETU/subcarrier counting
  always_comb begin
    state_next  = state_reg;
    bit_next    = bit_reg;
    data_next   = data_reg;
    nbits_next  = nbits_reg;
    par_en_next = par_en_reg;
    last_next   = last_reg;
    ready_c     = 1'b0;
    underrun_c  = 1'b0;
    load_byte   = 1'b0;

    case (state_reg)
      S_IDLE: begin
        ready_c = 1'b1;
        if (tvalid) begin
          load_byte  = 1'b1;
          state_next = S_SOF;
        end
      end
      S_SOF: begin
        if (etu_end) begin
          state_next = S_DATA;
          bit_next   = '0;
        end
      end
      S_DATA: begin
        if (etu_end) begin
          if ({1'b0, bit_reg} == nbits_reg - 4'd1) begin
            // A partial byte has no parity and always closes the frame
            state_next = par_en_reg ? S_PARITY : S_EOF;
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (etu_end) begin
          if (last_reg) begin
            state_next = S_EOF;
          end else begin
            // Byte boundary: next byte must be ready now, no gap allowed
            ready_c = 1'b1;
            if (tvalid) begin
              load_byte  = 1'b1;
              state_next = S_DATA;
              bit_next   = '0;
            end else begin
              underrun_c = 1'b1;
              state_next = S_EOF;
            end
          end
        end
      end
      S_EOF: begin
        if (etu_end) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    if (load_byte) begin
      data_next   = tdata;
      last_next   = tlast;
      // Out-of-range bit counts fall back to a full byte with parity
      par_en_next = (tdatab == 4'd0) || (tdatab > 4'd8);
      nbits_next  = par_en_next ? 4'd8 : tdatab;
    end

    if (state_reg == S_IDLE || etu_end) cnt_next = '0;
    else                                 cnt_next = cnt_reg + 1'b1;

    if (state_reg == S_IDLE || etu_end || sub_reg == SUB_LAST) sub_next = '0;
    else                                                        sub_next = sub_reg + 1'b1;
  end

  // Manchester coding of the current bit onto the subcarrier
  always_comb begin
    cur_bit    = 1'b0;
    load_mod_c = 1'b0;
    case (state_reg)
      S_SOF:    cur_bit = 1'b1;
      S_DATA:   cur_bit = data_reg[bit_reg];
      S_PARITY: cur_bit = ~^data_reg;
      default:  cur_bit = 1'b0;
    endcase
    mod_half = cur_bit ? (cnt_reg < ETU_HALF) : (cnt_reg >= ETU_HALF);
    if (state_reg == S_SOF || state_reg == S_DATA || state_reg == S_PARITY)
      load_mod_c = mod_half && (sub_reg < SUB_HALF);
  end

  assign tready   = ready_c & rstn;
  assign underrun = underrun_c;
  assign busy     = (state_reg != S_IDLE);
  assign load_mod = load_mod_c;

endmodule
